// File: rtl/adf4351_spi_writer.sv
// Streams ADF4351 register words over the 3-wire interface (ADF_CLK/ADF_DATA/ADF_LE).
// Full init writes R5..R0; retune writes R4 then R0 so the VCO band select runs last.
module adf4351_spi_writer #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [31:0] ADF_R1  = 32'h08008011,
  parameter logic [31:0] ADF_R2  = 32'h00004E42,
  parameter logic [31:0] ADF_R3  = 32'h000004B3,
  parameter logic [31:0] ADF_R5  = 32'h00580005
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        FULL_INIT,
  input  logic [31:0] ADF_R0,
  input  logic [31:0] ADF_R4,
  output logic        BUSY,
  output logic        DONE,
  output logic        ADF_CLK,
  output logic        ADF_DATA,
  output logic        ADF_LE
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LE_SETUP = 3'd3,
    LE_HIGH  = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [4:0]  bit_r;
  logic [2:0]  idx_r;
  logic        full_r;
  logic [31:0] r0_r;
  logic [31:0] r4_r;

  logic [31:0] cur_word_s;
  logic [31:0] next_word_s;
  logic [31:0] first_word_s;
  logic        last_word_s;
  logic        phase_end_s;

  function automatic logic [31:0] word_at(input logic [2:0] idx, input logic full,
                                          input logic [31:0] r0, input logic [31:0] r4);
    logic [31:0] w;
    if (full) begin
      case (idx)
        3'd0:    w = ADF_R5;
        3'd1:    w = r4;
        3'd2:    w = ADF_R3;
        3'd3:    w = ADF_R2;
        3'd4:    w = ADF_R1;
        default: w = r0;
      endcase
    end else begin
      case (idx)
        3'd0:    w = r4;
        default: w = r0;
      endcase
    end
    return w;
  endfunction

  // Word selection and phase-boundary decode
  always_comb begin
    phase_end_s  = (cnt_r == DIV_LAST);
    last_word_s  = full_r ? (idx_r == 3'd5) : (idx_r == 3'd1);
    cur_word_s   = word_at(idx_r, full_r, r0_r, r4_r);
    next_word_s  = word_at(idx_r + 3'd1, full_r, r0_r, r4_r);
    first_word_s = word_at(3'd0, FULL_INIT, ADF_R0, ADF_R4);
  end

  // Sequencer FSM with registered serial outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r  <= IDLE;
      cnt_r    <= 16'd0;
      bit_r    <= 5'd0;
      idx_r    <= 3'd0;
      full_r   <= 1'b0;
      r0_r     <= 32'd0;
      r4_r     <= 32'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ADF_CLK  <= 1'b0;
      ADF_DATA <= 1'b0;
      ADF_LE   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          DONE <= 1'b0;
          // The DONE cycle still counts as the tail of the previous sequence
          if (START && !DONE) begin
            r0_r     <= ADF_R0;
            r4_r     <= ADF_R4;
            full_r   <= FULL_INIT;
            idx_r    <= 3'd0;
            bit_r    <= 5'd31;
            cnt_r    <= 16'd0;
            BUSY     <= 1'b1;
            ADF_DATA <= first_word_s[31];
            state_r  <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (phase_end_s) begin
            cnt_r   <= 16'd0;
            ADF_CLK <= 1'b1;
            state_r <= SHIFT_HI;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        SHIFT_HI: begin
          if (phase_end_s) begin
            cnt_r   <= 16'd0;
            ADF_CLK <= 1'b0;
            if (bit_r != 5'd0) begin
              bit_r    <= bit_r - 5'd1;
              ADF_DATA <= cur_word_s[bit_r - 5'd1];
              state_r  <= SHIFT_LO;
            end else begin
              ADF_DATA <= 1'b0;
              state_r  <= LE_SETUP;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        LE_SETUP: begin
          if (phase_end_s) begin
            cnt_r   <= 16'd0;
            ADF_LE  <= 1'b1;
            state_r <= LE_HIGH;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        LE_HIGH: begin
          if (phase_end_s) begin
            cnt_r   <= 16'd0;
            ADF_LE  <= 1'b0;
            state_r <= GAP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        GAP: begin
          if (phase_end_s) begin
            cnt_r <= 16'd0;
            if (last_word_s) begin
              BUSY    <= 1'b0;
              DONE    <= 1'b1;
              state_r <= IDLE;
            end else begin
              idx_r    <= idx_r + 3'd1;
              bit_r    <= 5'd31;
              ADF_DATA <= next_word_s[31];
              state_r  <= SHIFT_LO;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 16'd0;
          BUSY     <= 1'b0;
          DONE     <= 1'b0;
          ADF_CLK  <= 1'b0;
          ADF_DATA <= 1'b0;
          ADF_LE   <= 1'b0;
        end
      endcase
    end
  end

endmodule
